// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: byte-lane enable constants, the store-buffer entry
// layout and the drain state machine states.
package mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int SB_WORD_W  = MEM_ADDR_W - 2;

  // Lane bit 0 is the most significant byte, data[31:24].
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HI   = 4'b0011;
  localparam logic [3:0] BE_LO   = 4'b1100;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;

  typedef struct packed {
    logic [SB_WORD_W-1:0] addr;
    logic [31:0]          data;
    logic [3:0]           be;
  } sb_entry_t;

  typedef enum logic {
    IDLE,
    REQ
  } sb_state_e;

endpackage

// File: rtl/sb_lane_merge.sv
// Per-byte-lane merge of new store data into an existing entry; enabled lanes take
// the new byte, the rest keep the old one.
module sb_lane_merge (
  input  logic [31:0] old_data,
  input  logic [3:0]  old_be,
  input  logic [31:0] new_data,
  input  logic [3:0]  new_we,
  output logic [31:0] merged_data,
  output logic [3:0]  merged_be
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_data[31-8*gi -: 8] = new_we[gi] ? new_data[31-8*gi -: 8]
                                                  : old_data[31-8*gi -: 8];
  end

  assign merged_be = old_be | new_we;

endmodule

// File: rtl/store_write_buffer.sv
// Store write buffer: queues byte-enabled stores, merges same-word stores into the tail
// entry, drains to the data-memory bus with req/ack and flags loads that hit pending stores.
module store_write_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [3:0]        st_we,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_stall,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  sb_entry_t mem [DEPTH];

  logic [PTR_W-1:0]     head_reg, tail_reg, tail_m1, wr_idx, nxt_idx;
  logic [CNT_W-1:0]     count_reg, count_next;
  sb_state_e            state_reg;
  logic                 bus_req_reg;
  logic [ADDR_W-1:0]    bus_addr_reg;
  logic [31:0]          bus_wdata_reg;
  logic [3:0]           bus_be_reg;
  logic [SB_WORD_W-1:0] st_word, ld_word;
  logic                 st_accept, issuing_tail, merge_en, push_en, pop_en, wr_en;
  sb_entry_t            merged, wr_val, nxt_entry;
  logic [DEPTH-1:0]     ld_hit;
  logic                 unused_addr_lsbs;

  assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_word   = SB_WORD_W'(st_addr[ADDR_W-1:2]);
  assign ld_word   = SB_WORD_W'(ld_addr[ADDR_W-1:2]);
  assign tail_m1   = tail_reg - PTR_ONE;
  assign st_accept = st_valid && st_ready && (st_we != 4'b0000);

  // The tail entry may be merged into unless it is the head already held on the bus.
  assign issuing_tail = (state_reg == REQ) && (head_reg == tail_m1);
  assign merge_en = st_accept && (count_reg != '0) && !issuing_tail &&
                    (mem[tail_m1].addr == st_word);
  assign push_en  = st_accept && !merge_en;
  assign pop_en   = (state_reg == REQ) && bus_ack;

  sb_lane_merge u_merge (
    .old_data    (mem[tail_m1].data),
    .old_be      (mem[tail_m1].be),
    .new_data    (st_data),
    .new_we      (st_we),
    .merged_data (merged.data),
    .merged_be   (merged.be)
  );
  assign merged.addr = st_word;

  assign wr_en  = merge_en || push_en;
  assign wr_idx = merge_en ? tail_m1 : tail_reg;
  assign wr_val = merge_en ? merged : '{addr: st_word, data: st_data, be: st_we};

  // Next entry to present on the bus, bypassing a store written in this same cycle.
  assign nxt_idx   = (state_reg == REQ) ? (head_reg + PTR_ONE) : head_reg;
  assign nxt_entry = (wr_en && (wr_idx == nxt_idx)) ? wr_val : mem[nxt_idx];

  always_comb begin
    count_next = count_reg;
    if (push_en && !pop_en) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop_en && !push_en) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      state_reg     <= IDLE;
      bus_req_reg   <= 1'b0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_be_reg    <= '0;
    end else begin
      count_reg <= count_next;
      if (push_en) begin
        tail_reg <= tail_reg + PTR_ONE;
      end
      if (pop_en) begin
        head_reg <= head_reg + PTR_ONE;
      end
      case (state_reg)
        IDLE: begin
          if (count_reg != '0) begin
            bus_req_reg   <= 1'b1;
            bus_addr_reg  <= {nxt_entry.addr[ADDR_W-3:0], 2'b00};
            bus_wdata_reg <= nxt_entry.data;
            bus_be_reg    <= nxt_entry.be;
            state_reg     <= REQ;
          end
        end
        REQ: begin
          if (bus_ack) begin
            if (count_next != '0) begin
              bus_addr_reg  <= {nxt_entry.addr[ADDR_W-3:0], 2'b00};
              bus_wdata_reg <= nxt_entry.data;
              bus_be_reg    <= nxt_entry.be;
            end else begin
              bus_req_reg <= 1'b0;
              state_reg   <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Occupancy of slot gi is judged by its distance from head, so the in-flight head counts.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    logic [PTR_W-1:0] offset;
    assign offset     = PTR_W'(gi) - head_reg;
    assign ld_hit[gi] = ({1'b0, offset} < count_reg) && (mem[gi].addr == ld_word);
  end

  assign ld_stall  = ld_valid && (|ld_hit);
  assign st_ready  = (count_reg < CNT_FULL);
  assign empty     = (count_reg == '0) && (state_reg == IDLE);
  assign bus_req   = bus_req_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign bus_be    = bus_be_reg;

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios plus a randomized run against a
// queue-based reference model of the buffer.
module tb_store_write_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [3:0]        st_we;
  logic              st_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_stall;
  logic              bus_req;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ack;
  logic              empty;

  int checks   = 0;
  int failures = 0;

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_we     (st_we),
    .st_ready  (st_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_stall  (ld_stall),
    .bus_req   (bus_req),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_be    (bus_be),
    .bus_ack   (bus_ack),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered list of pending words; m_req marks the front as on the bus.
  typedef struct packed {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  be;
  } ref_ent_t;

  ref_ent_t mq[$];
  bit       m_req;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[31-8*i -: 8] = 8'hFF;
    end
    return m;
  endfunction

  task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] we);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_we    = we;
  endtask

  // Advance one clock and apply the buffer's rules to the model with the inputs seen at the edge.
  task automatic tick();
    int       pre;
    bit       accept;
    bit       ack;
    ref_ent_t e;
    logic [31:0] m;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_req = 1'b0;
    end else begin
      pre    = mq.size();
      accept = st_valid && (pre < DEPTH) && (st_we != 4'b0000);
      ack    = m_req && bus_ack;
      if (accept) begin
        if (pre > 0 && mq[pre-1].word == st_addr[31:2] && !(m_req && pre == 1)) begin
          e = mq[pre-1];
          m = lane_mask(st_we);
          e.data = (e.data & ~m) | (st_data & m);
          e.be   = e.be | st_we;
          mq[pre-1] = e;
        end else begin
          e.word = st_addr[31:2];
          e.data = st_data;
          e.be   = st_we;
          mq.push_back(e);
        end
      end
      if (ack) begin
        void'(mq.pop_front());
        m_req = (mq.size() > 0);
      end else if (!m_req) begin
        m_req = (pre > 0);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    set_store(1'b0, '0, '0, 4'b0000);
    bus_ack  = 1'b0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    rst      = 1'b1;
    mq.delete();
    m_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ld_valid = 1'b1;
    ld_addr = '0;
    #2;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %0b expected 0", bus_req); end
    checks++; if (bus_addr !== 32'h0) begin failures++; $display("FAIL rst_addr: got %h expected 0", bus_addr); end
    checks++; if (bus_wdata !== 32'h0) begin failures++; $display("FAIL rst_wdata: got %h expected 0", bus_wdata); end
    checks++; if (bus_be !== 4'h0) begin failures++; $display("FAIL rst_be: got %b expected 0000", bus_be); end
    checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %0b expected 1", st_ready); end
    checks++; if (ld_stall !== 1'b0) begin failures++; $display("FAIL rst_stall: got %0b expected 0", ld_stall); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_empty: got %0b expected 1", empty); end
    do_reset();
    $display("test_reset done");
  endtask

  task automatic test_single_word();
    do_reset();
    set_store(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111);
    tick();
    set_store(1'b0, '0, '0, 4'b0000);
    #1;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL sw_latency: bus_req got %0b expected 0", bus_req); end
    tick();
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL sw_req: got %0b expected 1", bus_req); end
    checks++; if (bus_addr !== 32'h100) begin failures++; $display("FAIL sw_addr: got %h expected 00000100", bus_addr); end
    checks++; if (bus_be !== 4'b1111) begin failures++; $display("FAIL sw_be: got %b expected 1111", bus_be); end
    checks++; if (bus_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata: got %h expected deadbeef", bus_wdata); end
    checks++; if (empty !== 1'b0) begin failures++; $display("FAIL sw_busy: empty got %0b expected 0", empty); end
    repeat (2) tick();
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h100) begin failures++; $display("FAIL sw_hold: req %0b addr %h expected 1 00000100", bus_req, bus_addr); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL sw_drop: got %0b expected 0", bus_req); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL sw_empty: got %0b expected 1", empty); end
    $display("test_single_word done");
  endtask

  task automatic test_merge();
    do_reset();
    set_store(1'b1, 32'h100, 32'h11223344, 4'b1111);
    tick();
    set_store(1'b1, 32'h200, 32'hAA000000, 4'b0001);
    tick();
    set_store(1'b1, 32'h201, 32'h00BB0000, 4'b0010);
    tick();
    set_store(1'b0, '0, '0, 4'b0000);
    #1;
    checks++; if (bus_addr !== 32'h100) begin failures++; $display("FAIL mg_head: got %h expected 00000100", bus_addr); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checks++; if (bus_addr !== 32'h200) begin failures++; $display("FAIL mg_addr: got %h expected 00000200", bus_addr); end
    checks++; if (bus_be !== 4'b0011) begin failures++; $display("FAIL mg_be: got %b expected 0011", bus_be); end
    checks++; if ((bus_wdata & 32'hFFFF0000) !== 32'hAABB0000) begin failures++; $display("FAIL mg_data: got %h expected aabb0000", bus_wdata & 32'hFFFF0000); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checks++; if (bus_req !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL mg_single_entry: req %0b empty %0b expected 0 1", bus_req, empty); end
    $display("test_merge done");
  endtask

  task automatic test_full();
    logic [31:0] exp_addr [4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 32'h400 + 32'(4*i), $urandom, 4'b1111);
      tick();
    end
    set_store(1'b1, 32'h410, 32'h55667788, 4'b1111);
    #1;
    checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %0b expected 0", st_ready); end
    tick();
    checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL full_reject: got %0b expected 0", st_ready); end
    bus_ack = 1'b1;
    #1;
    checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL full_no_bypass: got %0b expected 0", st_ready); end
    tick();
    bus_ack = 1'b0;
    checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL full_after_pop: got %0b expected 1", st_ready); end
    tick();
    set_store(1'b0, '0, '0, 4'b0000);
    checks++; if (st_ready !== 1'b0) begin failures++; $display("FAIL full_refill: got %0b expected 0", st_ready); end
    exp_addr[0] = 32'h404; exp_addr[1] = 32'h408; exp_addr[2] = 32'h40C; exp_addr[3] = 32'h410;
    bus_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus_req !== 1'b1 || bus_addr !== exp_addr[k]) begin failures++; $display("FAIL full_drain%0d: req %0b addr %h expected 1 %h", k, bus_req, bus_addr, exp_addr[k]); end
      tick();
    end
    bus_ack = 1'b0;
    checks++; if (bus_req !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL full_done: req %0b empty %0b expected 0 1", bus_req, empty); end
    $display("test_full done");
  endtask

  task automatic test_load_hazard();
    do_reset();
    set_store(1'b1, 32'h300, 32'h01020304, 4'b1111);
    tick();
    set_store(1'b0, '0, '0, 4'b0000);
    ld_valid = 1'b1; ld_addr = 32'h302; #1;
    checks++; if (ld_stall !== 1'b1) begin failures++; $display("FAIL ld_pending: got %0b expected 1", ld_stall); end
    tick();
    #1;
    checks++; if (ld_stall !== 1'b1) begin failures++; $display("FAIL ld_inflight: got %0b expected 1", ld_stall); end
    ld_addr = 32'h304; #1;
    checks++; if (ld_stall !== 1'b0) begin failures++; $display("FAIL ld_other_word: got %0b expected 0", ld_stall); end
    ld_valid = 1'b0; ld_addr = 32'h300; #1;
    checks++; if (ld_stall !== 1'b0) begin failures++; $display("FAIL ld_novalid: got %0b expected 0", ld_stall); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    ld_valid = 1'b1; #1;
    checks++; if (ld_stall !== 1'b0) begin failures++; $display("FAIL ld_after_ack: got %0b expected 0", ld_stall); end
    set_store(1'b1, 32'h600, 32'h0, 4'b1111);
    ld_addr = 32'h600; #1;
    checks++; if (ld_stall !== 1'b0) begin failures++; $display("FAIL ld_same_cycle: got %0b expected 0", ld_stall); end
    tick();
    set_store(1'b0, '0, '0, 4'b0000);
    checks++; if (ld_stall !== 1'b1) begin failures++; $display("FAIL ld_next_cycle: got %0b expected 1", ld_stall); end
    ld_valid = 1'b0;
    $display("test_load_hazard done");
  endtask

  task automatic test_back_to_back();
    int high_cycles;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 32'h500 + 32'(4*i), $urandom, 4'b1111);
      tick();
    end
    set_store(1'b0, '0, '0, 4'b0000);
    bus_ack = 1'b1;
    high_cycles = 0;
    for (int k = 0; k < 3; k++) begin
      if (bus_req === 1'b1) high_cycles++;
      checks++; if (bus_addr !== 32'h500 + 32'(4*k)) begin failures++; $display("FAIL b2b_addr%0d: got %h expected %h", k, bus_addr, 32'h500 + 32'(4*k)); end
      tick();
    end
    bus_ack = 1'b0;
    checks++; if (high_cycles != 3) begin failures++; $display("FAIL b2b_req_cycles: got %0d expected 3", high_cycles); end
    checks++; if (bus_req !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL b2b_drop: req %0b empty %0b expected 0 1", bus_req, empty); end
    $display("test_back_to_back done");
  endtask

  task automatic test_async_reset();
    do_reset();
    set_store(1'b1, 32'h700, 32'h1, 4'b1111);
    tick();
    set_store(1'b1, 32'h704, 32'h2, 4'b1111);
    tick();
    set_store(1'b0, '0, '0, 4'b0000);
    checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL ar_pre: req got %0b expected 1", bus_req); end
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    m_req = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL ar_req: got %0b expected 0", bus_req); end
    checks++; if (st_ready !== 1'b1) begin failures++; $display("FAIL ar_ready: got %0b expected 1", st_ready); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL ar_empty: got %0b expected 1", empty); end
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL ar_quiet%0d: req got %0b expected 0", k, bus_req); end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    bit exp_stall;
    logic [31:0] m;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      set_store(($urandom_range(0, 3) != 0),
                32'h100 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3)),
                $urandom, 4'($urandom_range(0, 15)));
      bus_ack  = ($urandom_range(0, 2) == 0);
      ld_valid = ($urandom_range(0, 1) == 1);
      ld_addr  = 32'h100 + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3));
      #1;
      exp_stall = 1'b0;
      foreach (mq[i]) if (ld_valid && mq[i].word == ld_addr[31:2]) exp_stall = 1'b1;
      checks++; if (ld_stall !== exp_stall) begin failures++; $display("FAIL rnd_stall c%0d: got %0b expected %0b", cyc, ld_stall, exp_stall); end
      checks++; if (st_ready !== (mq.size() < DEPTH)) begin failures++; $display("FAIL rnd_ready c%0d: got %0b expected %0b", cyc, st_ready, (mq.size() < DEPTH)); end
      checks++; if (empty !== (mq.size() == 0 && !m_req)) begin failures++; $display("FAIL rnd_empty c%0d: got %0b expected %0b", cyc, empty, (mq.size() == 0 && !m_req)); end
      checks++; if (bus_req !== m_req) begin failures++; $display("FAIL rnd_req c%0d: got %0b expected %0b", cyc, bus_req, m_req); end
      if (m_req && mq.size() > 0) begin
        m = lane_mask(mq[0].be);
        checks++; if (bus_addr !== {mq[0].word, 2'b00}) begin failures++; $display("FAIL rnd_addr c%0d: got %h expected %h", cyc, bus_addr, {mq[0].word, 2'b00}); end
        checks++; if (bus_be !== mq[0].be) begin failures++; $display("FAIL rnd_be c%0d: got %b expected %b", cyc, bus_be, mq[0].be); end
        checks++; if ((bus_wdata & m) !== (mq[0].data & m)) begin failures++; $display("FAIL rnd_wdata c%0d: got %h expected %h", cyc, bus_wdata & m, mq[0].data & m); end
      end
      tick();
    end
    set_store(1'b0, '0, '0, 4'b0000);
    bus_ack  = 1'b0;
    ld_valid = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1;
    set_store(1'b0, '0, '0, 4'b0000);
    bus_ack  = 1'b0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    #1;
    test_reset();
    test_single_word();
    test_merge();
    test_full();
    test_load_hazard();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
